// File: rtl/banana_pixel_fetch.sv
// banana_pixel_fetch
// Consumer end of the banana sprite address path. Selects the banana that
// covers the current pixel, issues one sprite-ROM read and returns the colour
// index two cycles later (fully pipelined, one pixel per cycle). Also owns the
// banana animation frame counter and the collection flags / score.
// Optional build macro: BANANA_RESPAWN_EN -- once every banana is collected,
// all bananas re-arm after RESPAWN_FRAMES frame_start pulses (score is kept).
module banana_pixel_fetch #(
   parameter int NUM_BANANAS    = 5,
   parameter int FRAMES         = 8,
   parameter int FRAME_DIV      = 4,
   parameter int PIX_W          = 5,
   parameter int RESPAWN_FRAMES = 120
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      frame_start,
   input  logic [15:0]               X,
   input  logic [9:0]                DrawX,
   input  logic [9:0]                DrawY,
   input  logic                      pix_valid,
   input  logic [19*NUM_BANANAS-1:0] addr_in,
   output logic [18:0]               framenum,
   output logic [18:0]               rom_addr,
   input  logic [PIX_W-1:0]          rom_data,
   input  logic [15:0]               kong_left,
   input  logic [15:0]               kong_right,
   input  logic [9:0]                kong_top,
   input  logic [9:0]                kong_bottom,
   output logic                      banana_on,
   output logic [PIX_W-1:0]          banana_color,
   output logic                      pix_valid_out,
   output logic [NUM_BANANAS-1:0]    collected,
   output logic [7:0]                banana_count,
   output logic                      collect_pulse
);

   // ------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------
   localparam int FN_W  = (FRAMES    > 1) ? $clog2(FRAMES)    : 1;
   localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

   localparam logic [FN_W-1:0]  FN_LAST  = FN_W'(FRAMES - 32'sd1);
   localparam logic [FN_W-1:0]  FN_ONE   = FN_W'(32'sd1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 32'sd1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(32'sd1);

   // Banana anchors (top-left corner of each 32x32 box); the table is fixed
   // for five bananas. Index 0 is the rightmost element of each packed table.
   localparam logic [4:0][16:0] BX_TAB = {17'd2562, 17'd2099, 17'd1500, 17'd1335, 17'd943};
   localparam logic [4:0][9:0]  BY_TAB = {10'd336,  10'd286,  10'd270,  10'd270,  10'd255};

`ifdef BANANA_RESPAWN_EN
   localparam int RSP_W = $clog2(RESPAWN_FRAMES + 1);
   localparam logic [RSP_W-1:0] RSP_LAST = RSP_W'(RESPAWN_FRAMES - 32'sd1);
   localparam logic [RSP_W-1:0] RSP_ONE  = RSP_W'(32'sd1);
`endif

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------
   // Pixel (world column px, screen row py) inside the 32x32 box at (bx, by).
   function automatic logic in_box(input logic [16:0] px, input logic [9:0] py,
                                   input logic [16:0] bx, input logic [9:0] by);
      in_box = (px >= bx) && (px < (bx + 17'd32)) &&
               (py >= by) && (py < (by + 10'd32));
   endfunction

   // Inclusive Kong box intersects the inclusive 32x32 banana box at (bx, by).
   function automatic logic box_overlap(input logic [16:0] kl, input logic [16:0] kr,
                                        input logic [9:0]  kt, input logic [9:0]  kb,
                                        input logic [16:0] bx, input logic [9:0]  by);
      box_overlap = (kl <= (bx + 17'd31)) && (kr >= bx) &&
                    (kt <= (by + 10'd31)) && (kb >= by);
   endfunction

   // Number of set bits in a per-banana vector.
   function automatic logic [7:0] popcount(input logic [NUM_BANANAS-1:0] v);
      logic [7:0] c;
      c = 8'd0;
      for (int k = 0; k < NUM_BANANAS; k++) begin
         c = c + {7'd0, v[k]};
      end
      popcount = c;
   endfunction

   // Score addition that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[8]) begin
         sat_add8 = 8'hFF;
      end else begin
         sat_add8 = sum[7:0];
      end
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [18:0]            rom_addr_q,      rom_addr_d;
   logic                   s0_hit_q,        s0_hit_d;
   logic                   s0_valid_q,      s0_valid_d;
   logic                   banana_on_q,     banana_on_d;
   logic [PIX_W-1:0]       banana_color_q,  banana_color_d;
   logic                   pix_valid_out_q, pix_valid_out_d;
   logic [DIV_W-1:0]       div_q,           div_d;
   logic [FN_W-1:0]        frame_q,         frame_d;
   logic [NUM_BANANAS-1:0] collected_q,     collected_d;
   logic [7:0]             count_q,         count_d;
   logic                   pulse_q,         pulse_d;
`ifdef BANANA_RESPAWN_EN
   logic [RSP_W-1:0]       respawn_q,       respawn_d;
`endif

   // World column is 17 bits so a large scroll offset never wraps into a banana.
   logic [16:0]            wx_s;
   logic [NUM_BANANAS-1:0] hit_vec_s;
   logic [NUM_BANANAS-1:0] overlap_s;
   logic [NUM_BANANAS-1:0] newly_s;
   logic [18:0]            win_addr_s;
   logic                   any_hit_s;

   assign wx_s = {1'b0, X} + {7'd0, DrawX};

   // Per-banana pixel hit (against the pre-update collected flags) and Kong overlap.
   genvar gi;
   for (gi = 0; gi < NUM_BANANAS; gi++) begin : g_banana
      assign hit_vec_s[gi] = pix_valid && !collected_q[gi] &&
                             in_box(wx_s, DrawY, BX_TAB[gi], BY_TAB[gi]);
      assign overlap_s[gi] = box_overlap({1'b0, kong_left}, {1'b0, kong_right},
                                         kong_top, kong_bottom,
                                         BX_TAB[gi], BY_TAB[gi]);
   end

   assign newly_s = ~collected_q & overlap_s;

   // Priority select: scanning from the top index down lets the lowest index win.
   always_comb begin
      win_addr_s = rom_addr_q;
      any_hit_s  = 1'b0;
      for (int k = NUM_BANANAS - 1; k >= 0; k--) begin
         if (hit_vec_s[k]) begin
            win_addr_s = addr_in[19*k +: 19];
            any_hit_s  = 1'b1;
         end else begin
            win_addr_s = win_addr_s;
            any_hit_s  = any_hit_s;
         end
      end
   end

   // Next state for the two pixel stages: address issue, then colour capture.
   always_comb begin
      rom_addr_d      = win_addr_s;
      s0_hit_d        = any_hit_s;
      s0_valid_d      = pix_valid;
      banana_on_d     = s0_hit_q && (rom_data != {PIX_W{1'b0}});
      pix_valid_out_d = s0_valid_q;
      if (s0_hit_q) begin
         banana_color_d = rom_data;
      end else begin
         banana_color_d = {PIX_W{1'b0}};
      end
   end

   // Next state for the animation divider and frame number.
   always_comb begin
      div_d   = div_q;
      frame_d = frame_q;
      if (frame_start) begin
         if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
            if (frame_q == FN_LAST) begin
               frame_d = {FN_W{1'b0}};
            end else begin
               frame_d = frame_q + FN_ONE;
            end
         end else begin
            div_d = div_q + DIV_ONE;
         end
      end else begin
         div_d   = div_q;
         frame_d = frame_q;
      end
   end

   // Next state for collection flags, score, pulse and (optionally) respawn timer.
   always_comb begin
      collected_d = collected_q;
      count_d     = count_q;
      pulse_d     = 1'b0;
      if (frame_start) begin
         collected_d = collected_q | newly_s;
         count_d     = sat_add8(count_q, popcount(newly_s));
         pulse_d     = |newly_s;
      end else begin
         collected_d = collected_q;
         count_d     = count_q;
      end
`ifdef BANANA_RESPAWN_EN
      respawn_d = respawn_q;
      if (&collected_q) begin
         if (frame_start) begin
            if (respawn_q == RSP_LAST) begin
               collected_d = {NUM_BANANAS{1'b0}};
               respawn_d   = {RSP_W{1'b0}};
            end else begin
               respawn_d = respawn_q + RSP_ONE;
            end
         end else begin
            respawn_d = respawn_q;
         end
      end else begin
         respawn_d = {RSP_W{1'b0}};
      end
`endif
   end

   // Pixel pipeline registers; reset drops any pixel in flight.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         rom_addr_q      <= 19'd0;
         s0_hit_q        <= 1'b0;
         s0_valid_q      <= 1'b0;
         banana_on_q     <= 1'b0;
         banana_color_q  <= {PIX_W{1'b0}};
         pix_valid_out_q <= 1'b0;
      end else begin
         rom_addr_q      <= rom_addr_d;
         s0_hit_q        <= s0_hit_d;
         s0_valid_q      <= s0_valid_d;
         banana_on_q     <= banana_on_d;
         banana_color_q  <= banana_color_d;
         pix_valid_out_q <= pix_valid_out_d;
      end
   end

   // Animation registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         div_q   <= {DIV_W{1'b0}};
         frame_q <= {FN_W{1'b0}};
      end else begin
         div_q   <= div_d;
         frame_q <= frame_d;
      end
   end

   // Collection registers.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         collected_q <= {NUM_BANANAS{1'b0}};
         count_q     <= 8'd0;
         pulse_q     <= 1'b0;
      end else begin
         collected_q <= collected_d;
         count_q     <= count_d;
         pulse_q     <= pulse_d;
      end
   end

`ifdef BANANA_RESPAWN_EN
   // Respawn timer register.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         respawn_q <= {RSP_W{1'b0}};
      end else begin
         respawn_q <= respawn_d;
      end
   end
`endif

   assign rom_addr      = rom_addr_q;
   assign banana_on     = banana_on_q;
   assign banana_color  = banana_color_q;
   assign pix_valid_out = pix_valid_out_q;
   assign framenum      = {{(19-FN_W){1'b0}}, frame_q};
   assign collected     = collected_q;
   assign banana_count  = count_q;
   assign collect_pulse = pulse_q;

endmodule

// File: tb/tb_banana_pixel_fetch.sv
// Self-checking bench for banana_pixel_fetch (default build).
// Directed cases plus randomized traffic against a behavioural model; pixel
// results go through a scoreboard queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_banana_pixel_fetch;

   localparam int NB = 5;
   localparam int BX [NB] = '{943, 1335, 1500, 2099, 2562};
   localparam int BY [NB] = '{255, 270, 270, 286, 336};

   logic          Clk;
   logic          Reset;
   logic          frame_start;
   logic [15:0]   X;
   logic [9:0]    DrawX;
   logic [9:0]    DrawY;
   logic          pix_valid;
   logic [94:0]   addr_in;
   logic [18:0]   framenum;
   logic [18:0]   rom_addr;
   logic [4:0]    rom_data;
   logic [15:0]   kong_left;
   logic [15:0]   kong_right;
   logic [9:0]    kong_top;
   logic [9:0]    kong_bottom;
   logic          banana_on;
   logic [4:0]    banana_color;
   logic          pix_valid_out;
   logic [4:0]    collected;
   logic [7:0]    banana_count;
   logic          collect_pulse;

   banana_pixel_fetch dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .X(X),
      .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid), .addr_in(addr_in),
      .framenum(framenum), .rom_addr(rom_addr), .rom_data(rom_data),
      .kong_left(kong_left), .kong_right(kong_right), .kong_top(kong_top),
      .kong_bottom(kong_bottom), .banana_on(banana_on), .banana_color(banana_color),
      .pix_valid_out(pix_valid_out), .collected(collected),
      .banana_count(banana_count), .collect_pulse(collect_pulse)
   );

   // Sprite ROM contents: a fixed hash of the address; zero means transparent.
   function automatic logic [4:0] rom_word(input logic [18:0] a);
      return a[4:0] ^ a[9:5] ^ a[14:10];
   endfunction

   assign rom_data = rom_word(rom_addr);

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      logic       on;
      logic [4:0] color;
      int         due;
   } exp_t;

   exp_t sbq [$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state
   logic [4:0]  m_coll;
   int          m_count;
   int          m_pulses;
   logic        m_pulse;
   logic [18:0] m_rom;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: each pixel the DUT presents is compared with the oldest expectation.
   always @(negedge Clk) begin
      exp_t e;
      if (pix_valid_out === 1'b1) begin
         checks = checks + 1;
         if (sbq.size() == 0) begin
            errors = errors + 1;
            $display("FAIL pixel_extra actual pix_valid_out=1 required no pending pixel (cycle %0d)", cyc);
         end else begin
            e = sbq.pop_front();
            if (banana_on !== e.on || banana_color !== e.color || cyc != e.due) begin
               errors = errors + 1;
               $display("FAIL pixel actual on=%0b color=%0d cycle=%0d required on=%0b color=%0d cycle=%0d",
                        banana_on, banana_color, cyc, e.on, e.color, e.due);
            end
         end
      end
   end

   task automatic kong_far();
      kong_left = 16'd0; kong_right = 16'd16; kong_top = 10'd0; kong_bottom = 10'd8;
   endtask

   // Apply the current inputs for one clock, update the model, check state.
   task automatic step();
      int         w;
      int         wx;
      exp_t       e;
      logic [4:0] ov;
      logic [4:0] newly;
      wx = int'(X) + int'(DrawX);
      w  = -1;
      if (Reset && pix_valid) begin
         for (int i = 0; i < NB; i++) begin
            if (w < 0 && wx >= BX[i] && wx < BX[i] + 32 &&
                int'(DrawY) >= BY[i] && int'(DrawY) < BY[i] + 32 && !m_coll[i])
               w = i;
         end
         if (w >= 0) begin
            e.color = rom_word(addr_in[19*w +: 19]);
            e.on    = (e.color != 5'd0);
            m_rom   = addr_in[19*w +: 19];
         end else begin
            e.color = 5'd0;
            e.on    = 1'b0;
         end
         e.due = cyc + 2;
         sbq.push_back(e);
      end
      m_pulse = 1'b0;
      if (!Reset) begin
         m_coll = 5'd0; m_count = 0; m_pulses = 0; m_rom = 19'd0;
      end else if (frame_start) begin
         for (int i = 0; i < NB; i++) begin
            ov[i] = (int'(kong_left) <= BX[i] + 31) && (int'(kong_right) >= BX[i]) &&
                    (int'(kong_top) <= BY[i] + 31) && (int'(kong_bottom) >= BY[i]);
         end
         newly    = ov & ~m_coll;
         m_coll   = m_coll | newly;
         m_count  = m_count + $countones(newly);
         if (m_count > 255) m_count = 255;
         m_pulse  = (newly != 5'd0);
         m_pulses = m_pulses + 1;
      end
      @(posedge Clk);
      if (!Reset) sbq.delete();
      #1;
      check("rom_addr", {13'd0, rom_addr}, {13'd0, m_rom});
      check("framenum", {13'd0, framenum}, 32'((m_pulses / 4) % 8));
      check("collected", {27'd0, collected}, {27'd0, m_coll});
      check("banana_count", {24'd0, banana_count}, 32'(m_count));
      check("collect_pulse", {31'd0, collect_pulse}, {31'd0, m_pulse});
      if (!Reset) begin
         check("reset_pix_valid_out", {31'd0, pix_valid_out}, 32'd0);
         check("reset_banana_on", {31'd0, banana_on}, 32'd0);
      end
   endtask

   task automatic rand_addr();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      addr_in = r[94:0];
   endtask

   task automatic pixel(input int xs, input int dx, input int dy);
      X = 16'(xs); DrawX = 10'(dx); DrawY = 10'(dy); pix_valid = 1'b1;
   endtask

   task automatic rand_phase(input int n);
      int k, j, wt, dx, lft, tp;
      for (int c = 0; c < n; c++) begin
         k  = $urandom_range(0, NB - 1);
         wt = BX[k] + int'($urandom_range(0, 40)) - 4;
         dx = int'($urandom_range(0, 1023));
         DrawX = 10'(dx);
         if (wt >= dx) X = 16'(wt - dx); else X = 16'd0;
         DrawY = 10'(BY[k] + int'($urandom_range(0, 40)) - 4);
         pix_valid   = ($urandom_range(0, 3) != 0);
         frame_start = ($urandom_range(0, 7) == 0);
         rand_addr();
         if ($urandom_range(0, 30) == 0) begin
            j   = $urandom_range(0, NB - 1);
            lft = BX[j] + int'($urandom_range(0, 60)) - 40;
            tp  = BY[j] + int'($urandom_range(0, 60)) - 40;
            kong_left   = 16'(lft);
            kong_right  = 16'(lft + int'($urandom_range(0, 40)));
            kong_top    = 10'(tp);
            kong_bottom = 10'(tp + int'($urandom_range(0, 40)));
         end else begin
            kong_far();
         end
         step();
      end
   endtask

   // Boundary pixels around banana 0 (world 943..974, rows 255..286).
   localparam int BND_N = 8;
   localparam int BND_WX [BND_N] = '{942, 943, 974, 975, 950, 950, 950, 950};
   localparam int BND_Y  [BND_N] = '{260, 260, 260, 260, 254, 255, 286, 287};

   initial begin
      Reset = 1'b0; frame_start = 1'b0; X = 16'd0; DrawX = 10'd400; DrawY = 10'd260;
      pix_valid = 1'b0; addr_in = 95'd0; kong_far();
      m_coll = 5'd0; m_count = 0; m_pulses = 0; m_pulse = 1'b0; m_rom = 19'd0;

      // Reset state
      step(); step();
      Reset = 1'b1;

      // Banana 0 hit with known address, then transparent word
      rand_addr(); addr_in[18:0] = 19'h00127;
      pixel(600, 350, 260); step();
      addr_in[18:0] = 19'h00000; step();
      pix_valid = 1'b0; step();

      // Banana 2 hit; then boundary table; then 16-bit wrap must not hit
      rand_addr(); pixel(1000, 510, 280); step();
      for (int b = 0; b < BND_N; b++) begin
         rand_addr(); pixel(BND_WX[b] - 300, 300, BND_Y[b]); step();
      end
      rand_addr(); pixel(65535, 951, 260); step();
      pix_valid = 1'b0; step(); step();

      // Animation: 32 pulses wrap framenum back to 0
      for (int p = 0; p < 32; p++) begin
         frame_start = 1'b1; step();
         frame_start = 1'b0; step();
      end

      // Collect banana 0, then same box again: no change, no pulse
      kong_left = 16'd940; kong_right = 16'd980; kong_top = 10'd250; kong_bottom = 10'd300;
      frame_start = 1'b1; step();
      frame_start = 1'b0; step();
      frame_start = 1'b1; step();
      frame_start = 1'b0; kong_far(); step();

      // Collect banana 2 while its pixel is in stage 0 (pre-update flags apply)
      kong_left = 16'd1505; kong_right = 16'd1510; kong_top = 10'd275; kong_bottom = 10'd280;
      rand_addr(); pixel(1000, 510, 280); frame_start = 1'b1; step();
      frame_start = 1'b0; kong_far(); rand_addr(); step();
      pix_valid = 1'b0; step(); step();

      // Randomized traffic
      rand_phase(1200);

      // Reset with a pixel in flight
      frame_start = 1'b0; kong_far(); Reset = 1'b1; rand_addr(); pixel(600, 350, 260); step();
      Reset = 1'b0; pix_valid = 1'b0; step();
      Reset = 1'b1; step();

      rand_phase(1200);

      pix_valid = 1'b0; frame_start = 1'b0; kong_far();
      repeat (4) step();
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/banana_pixel_fetch.md
Name: banana_pixel_fetch

Overview:
- Consumer end of the banana sprite address path: takes the five per-banana ROM addresses, decides which banana (if any) covers the current pixel, issues one sprite-ROM read, and returns the colour index two cycles later.
- Owns the banana animation counter (drives framenum back to the address generator).
- Owns banana collection state: per-banana collected flags and the banana score.
- Sits between the address generator / sprite ROM and the colour mapper.

Parameters:
- NUM_BANANAS, 5, number of bananas; anchor table is fixed for 5.
- FRAMES, 8, animation frames per cycle; each frame is 1024 ROM words.
- FRAME_DIV, 4, frame_start pulses per animation step.
- PIX_W, 5, sprite ROM data width (palette index); index 0 is transparent.
- RESPAWN_FRAMES, 120, frame_start pulses before respawn (optional feature only).

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous, active-low.
- frame_start, in, 1, one-cycle pulse per vsync.
- X, in, 16, world scroll offset.
- DrawX, in, 10, current pixel column.
- DrawY, in, 10, current pixel row.
- pix_valid, in, 1, DrawX/DrawY valid this cycle.
- addr_in, in, 19*NUM_BANANAS, packed per-banana ROM addresses; banana i at bits [19i+18:19i].
- framenum, out, 19, current animation frame, zero-extended.
- rom_addr, out, 19, sprite ROM address.
- rom_data, in, PIX_W, ROM data, valid 1 cycle after rom_addr.
- kong_left, in, 16, Kong bounding box, world coordinates, inclusive.
- kong_right, in, 16, Kong bounding box, world coordinates, inclusive.
- kong_top, in, 10, Kong bounding box, screen rows, inclusive.
- kong_bottom, in, 10, Kong bounding box, screen rows, inclusive.
- banana_on, out, 1, opaque banana pixel.
- banana_color, out, PIX_W, palette index.
- pix_valid_out, out, 1, pix_valid delayed 2 cycles.
- collected, out, NUM_BANANAS, per-banana collected flags.
- banana_count, out, 8, score, saturates at 255.
- collect_pulse, out, 1, one cycle when at least one banana is newly collected.

Behaviour:
- Reset (Reset==0 at posedge): clears all pipeline registers, framenum, the frame_start pulse counter, collected, banana_count, collect_pulse, banana_on, banana_color and pix_valid_out. rom_addr resets to 0.
- Anchors (top-left of a 32x32 box):
  - BX = 943, 1335, 1500, 2099, 2562.
  - BY = 255, 270, 270, 286, 336.
- World column: wx = X + DrawX, computed 17 bits wide with no wrap.
- Stage 0 (cycle of pix_valid): banana i hits when all of the following hold:
  - BX[i] <= wx < BX[i]+32;
  - BY[i] <= DrawY < BY[i]+32;
  - collected[i] == 0;
  - pix_valid == 1.
- Stage 0 priority: lowest index wins. Register rom_addr = addr_in[winner], hit flag, and the valid bit. With no hit, rom_addr holds its previous value and the hit flag is 0.
- Stage 1: rom_data is valid. Register the outputs:
  - banana_on = hit & (rom_data != 0);
  - banana_color = hit ? rom_data : 0;
  - pix_valid_out = stage-0 valid.
- Total latency is 2 cycles. The pipeline is fully pipelined: one pixel per cycle, no stalls.
- Animation: count frame_start pulses from 0 to FRAME_DIV-1. On the pulse that wraps the count, framenum = (framenum+1) mod FRAMES.
- Collection is evaluated only on frame_start cycles:
  - newly = ~collected & overlap, where overlap[i] means the Kong box intersects banana i's box (inclusive bounds).
  - collected |= newly.
  - banana_count += popcount(newly), saturating at 255.
  - collect_pulse = (newly != 0), asserted the next cycle for 1 cycle.
- Simultaneous frame_start and pix_valid: stage 0 uses the pre-update collected value. The update becomes visible to pixels from the next cycle.
- Reset mid-pipeline: in-flight pixels are dropped; pix_valid_out is 0 the cycle after reset.

Optional Feature:
- Macro: BANANA_RESPAWN_EN.
- Defined: once collected is all ones, count frame_start pulses. After RESPAWN_FRAMES pulses, clear collected; banana_count is kept. The respawn counter resets whenever collected is not all ones.
- Undefined: collected stays set until Reset. The respawn counter is not synthesized.

Test Plan:
- Reset, X=0, DrawX=400, DrawY=260, all other inputs idle -> banana_on=0, framenum=0, collected=0, banana_count=0.
- X=600, DrawX=350 (wx=950), DrawY=260, pix_valid=1, addr_in[0]=0x0127, rom_data=5 -> rom_addr=0x0127 one cycle later; banana_on=1 and banana_color=5 at cycle +2. Repeat with rom_data=0 -> banana_on=0.
- wx=1510, DrawY=280: banana 2 hits. With banana 2 collected, the same pixel -> banana_on=0 and rom_addr is not updated.
- 8 frame_start pulses with FRAME_DIV=4 -> framenum steps 0->1 on the 4th pulse and 1->2 on the 8th. Continue to 32 pulses -> framenum wraps to 0.
- Kong box 940..980 x 250..300, frame_start -> collected=00001, banana_count=1, collect_pulse high for 1 cycle. Second frame_start with the same box -> no change, no pulse.
- With BANANA_RESPAWN_EN and RESPAWN_FRAMES=3: collect all 5 -> count=5; after 3 frame_starts, collected=0 and count stays 5.
